// File: rtl/ddr_write_arbiter_pkg.sv
// Shared definitions for the DDR write arbiter: FSM state encoding and burst length default.
package ddr_write_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam int DATA_BEATS_DEFAULT = 2;

endpackage

// File: rtl/ddr_write_arbiter.sv
// Two-master arbiter in front of the DDR address/write-data FIFOs. The owner holds the FIFOs for
// one burst (one af beat plus DATA_BEATS wdf beats); the other master sees both FIFOs full.
module ddr_write_arbiter
    import ddr_write_arbiter_pkg::*;
#(
    parameter int DATA_BEATS = DATA_BEATS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         m0_req,
    output logic         m0_gnt,
    input  logic [30:0]  m0_af_addr_din,
    input  logic         m0_af_wr_en,
    input  logic [127:0] m0_wdf_din,
    input  logic [15:0]  m0_wdf_mask_din,
    input  logic         m0_wdf_wr_en,
    output logic         m0_af_full,
    output logic         m0_wdf_full,
    input  logic         m1_req,
    output logic         m1_gnt,
    input  logic [30:0]  m1_af_addr_din,
    input  logic         m1_af_wr_en,
    input  logic [127:0] m1_wdf_din,
    input  logic [15:0]  m1_wdf_mask_din,
    input  logic         m1_wdf_wr_en,
    output logic         m1_af_full,
    output logic         m1_wdf_full,
    input  logic         af_full,
    input  logic         wdf_full,
    output logic [30:0]  af_addr_din,
    output logic         af_wr_en,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din,
    output logic         wdf_wr_en,
    output arb_state_e   dbg_state
);

    localparam logic [1:0] BEATS = 2'(DATA_BEATS);

    arb_state_e state_q;
    logic       m0_gnt_q, m1_gnt_q;
    logic       addr_done_q, addr_done_d;
    logic [1:0] data_cnt_q, data_cnt_d;
    logic       last_served_q;

    logic own0, own1, owned;
    logic own_req, own_af_full, own_wdf_full;
    logic burst_done, abort_idle;

    // Ownership is masked during reset so strobes drop in the reset cycle itself.
    assign own0  = (state_q == ST_OWN0) && !rst;
    assign own1  = (state_q == ST_OWN1) && !rst;
    assign owned = own0 || own1;

    always_comb begin
        own_req      = own0 ? m0_req : m1_req;
        own_af_full  = af_full | addr_done_q;
        own_wdf_full = wdf_full | (data_cnt_q == BEATS);
        m0_af_full   = own0 ? own_af_full  : 1'b1;
        m0_wdf_full  = own0 ? own_wdf_full : 1'b1;
        m1_af_full   = own1 ? own_af_full  : 1'b1;
        m1_wdf_full  = own1 ? own_wdf_full : 1'b1;
        af_addr_din  = '0;
        af_wr_en     = 1'b0;
        wdf_din      = '0;
        wdf_mask_din = '0;
        wdf_wr_en    = 1'b0;
        if (owned) begin
            af_addr_din  = own0 ? m0_af_addr_din  : m1_af_addr_din;
            af_wr_en     = (own0 ? m0_af_wr_en    : m1_af_wr_en) & !own_af_full;
            wdf_din      = own0 ? m0_wdf_din      : m1_wdf_din;
            wdf_mask_din = own0 ? m0_wdf_mask_din : m1_wdf_mask_din;
            wdf_wr_en    = (own0 ? m0_wdf_wr_en   : m1_wdf_wr_en) & !own_wdf_full;
        end
        // Gated strobes cannot push the counter past BEATS, so a plain add saturates.
        addr_done_d = addr_done_q | af_wr_en;
        data_cnt_d  = data_cnt_q + {1'b0, wdf_wr_en};
        burst_done  = addr_done_d && (data_cnt_d == BEATS);
        abort_idle  = !own_req && !addr_done_d && (data_cnt_d == 2'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            m0_gnt_q      <= 1'b0;
            m1_gnt_q      <= 1'b0;
            addr_done_q   <= 1'b0;
            data_cnt_q    <= 2'd0;
            last_served_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (m0_req && (!m1_req || last_served_q)) begin
                        state_q  <= ST_OWN0;
                        m0_gnt_q <= 1'b1;
                    end else if (m1_req) begin
                        state_q  <= ST_OWN1;
                        m1_gnt_q <= 1'b1;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    if (burst_done || abort_idle) begin
                        state_q     <= ST_IDLE;
                        m0_gnt_q    <= 1'b0;
                        m1_gnt_q    <= 1'b0;
                        addr_done_q <= 1'b0;
                        data_cnt_q  <= 2'd0;
                        if (burst_done)
                            last_served_q <= (state_q == ST_OWN1);
                    end else begin
                        addr_done_q <= addr_done_d;
                        data_cnt_q  <= data_cnt_d;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    m0_gnt_q <= 1'b0;
                    m1_gnt_q <= 1'b0;
                end
            endcase
        end
    end

    assign m0_gnt    = m0_gnt_q;
    assign m1_gnt    = m1_gnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Directed bench for ddr_write_arbiter: grant order, burst gating, stalls, held grant and reset abort.
module tb_ddr_write_arbiter;
    import ddr_write_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         m0_req, m0_gnt, m0_af_wr_en, m0_wdf_wr_en, m0_af_full, m0_wdf_full;
    logic [30:0]  m0_af_addr_din;
    logic [127:0] m0_wdf_din;
    logic [15:0]  m0_wdf_mask_din;
    logic         m1_req, m1_gnt, m1_af_wr_en, m1_wdf_wr_en, m1_af_full, m1_wdf_full;
    logic [30:0]  m1_af_addr_din;
    logic [127:0] m1_wdf_din;
    logic [15:0]  m1_wdf_mask_din;
    logic         af_full, wdf_full, af_wr_en, wdf_wr_en;
    logic [30:0]  af_addr_din;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;
    arb_state_e   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int af_cnt   = 0;
    int af_base;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    ddr_write_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_af_addr_din(m0_af_addr_din),
        .m0_af_wr_en(m0_af_wr_en), .m0_wdf_din(m0_wdf_din), .m0_wdf_mask_din(m0_wdf_mask_din),
        .m0_wdf_wr_en(m0_wdf_wr_en), .m0_af_full(m0_af_full), .m0_wdf_full(m0_wdf_full),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_af_addr_din(m1_af_addr_din),
        .m1_af_wr_en(m1_af_wr_en), .m1_wdf_din(m1_wdf_din), .m1_wdf_mask_din(m1_wdf_mask_din),
        .m1_wdf_wr_en(m1_wdf_wr_en), .m1_af_full(m1_af_full), .m1_wdf_full(m1_wdf_full),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en), .wdf_din(wdf_din),
        .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input int m, input logic af_en, input logic [30:0] addr,
                       input logic wdf_en, input logic [127:0] d);
        if (m == 0) begin
            m0_af_wr_en = af_en; m0_af_addr_din = addr;
            m0_wdf_wr_en = wdf_en; m0_wdf_din = d; m0_wdf_mask_din = d[15:0];
        end else begin
            m1_af_wr_en = af_en; m1_af_addr_din = addr;
            m1_wdf_wr_en = wdf_en; m1_wdf_din = d; m1_wdf_mask_din = d[15:0];
        end
    endtask

    // Master m is granted in the current cycle; address + first beat, then second beat.
    task automatic burst(input int m, input logic [30:0] addr, input logic [127:0] d0,
                         input logic [127:0] d1, input logic drop);
        drv(m, 1'b1, addr, 1'b1, d0);
        exp_q.push_back(d0);
        #1;
        chk("burst_af_en", af_wr_en, 1'b1);
        chk("burst_addr", af_addr_din, addr);
        chk("burst_mask", wdf_mask_din, d0[15:0]);
        cyc();
        if (drop) begin
            if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
        end
        drv(m, 1'b0, '0, 1'b1, d1);
        exp_q.push_back(d1);
        #1;
        chk("burst_af_full", (m == 0) ? m0_af_full : m1_af_full, 1'b1);
        chk("burst_wdf_en", wdf_wr_en, 1'b1);
        cyc();
        drv(m, 1'b0, '0, 1'b0, '0);
        #1;
        chk("burst_idle", dbg_state, ST_IDLE);
    endtask

    always @(negedge clk) begin
        if (af_wr_en) af_cnt++;
        if (wdf_wr_en) begin
            if (exp_q.size() == 0) chk("wdf_unexpected", wdf_din, '0);
            else chk("wdf_data", wdf_din, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; af_full = 1'b0; wdf_full = 1'b0;
        drv(0, 1'b0, '0, 1'b0, '0);
        drv(1, 1'b0, '0, 1'b0, '0);
        repeat (3) cyc();
        #1;
        chk("rst_gnt0", m0_gnt, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_af_full0", m0_af_full, 1'b1);
        rst = 1'b0;

        // Single requester, non-owner strobes must be ignored
        cyc();
        m0_req = 1'b1;
        drv(1, 1'b1, 31'h7ff, 1'b1, 128'hbad);
        #1;
        chk("idle_gnt0", m0_gnt, 1'b0);
        chk("idle_af_en", af_wr_en, 1'b0);
        chk("idle_addr", af_addr_din, '0);
        cyc();
        #1;
        chk("s1_gnt0", m0_gnt, 1'b1);
        chk("s1_gnt1", m1_gnt, 1'b0);
        chk("s1_m1_af_full", m1_af_full, 1'b1);
        chk("s1_m1_wdf_full", m1_wdf_full, 1'b1);
        burst(0, 31'h100, 128'hd0, 128'hd1, 1'b1);
        drv(1, 1'b0, '0, 1'b0, '0);

        // Ties after reset: m0 first, then alternation
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        cyc();
        #1;
        chk("tie1_gnt0", m0_gnt, 1'b1);
        chk("tie1_gnt1", m1_gnt, 1'b0);
        burst(0, 31'h110, 128'ha0, 128'ha1, 1'b0);
        cyc();
        #1;
        chk("tie2_gnt1", m1_gnt, 1'b1);
        burst(1, 31'h120, 128'hb0, 128'hb1, 1'b0);
        cyc();
        #1;
        chk("tie3_gnt0", m0_gnt, 1'b1);
        burst(0, 31'h130, 128'hc0, 128'hc1, 1'b0);
        cyc();
        #1;
        chk("tie4_gnt1", m1_gnt, 1'b1);
        m0_req = 1'b0;
        burst(1, 31'h140, 128'he0, 128'he1, 1'b1);
        cyc();
        #1;
        chk("tie_end_idle", dbg_state, ST_IDLE);

        // Second address strobe in a burst is blocked
        m0_req = 1'b1;
        cyc();
        af_base = af_cnt;
        drv(0, 1'b1, 31'h200, 1'b0, '0);
        #1;
        chk("dbl_af_full0", m0_af_full, 1'b0);
        cyc();
        m0_req = 1'b0;
        drv(0, 1'b1, 31'h204, 1'b1, 128'h20);
        exp_q.push_back(128'h20);
        #1;
        chk("dbl_af_full1", m0_af_full, 1'b1);
        chk("dbl_af_en", af_wr_en, 1'b0);
        cyc();
        drv(0, 1'b0, '0, 1'b1, 128'h21);
        exp_q.push_back(128'h21);
        cyc();
        drv(0, 1'b0, '0, 1'b0, '0);
        #1;
        chk("dbl_idle", dbg_state, ST_IDLE);
        chk("dbl_af_count", af_cnt - af_base, 1);

        // Downstream full stalls the second data beat for 3 cycles
        m0_req = 1'b1;
        cyc();
        drv(0, 1'b1, 31'h300, 1'b1, 128'h30);
        exp_q.push_back(128'h30);
        cyc();
        m0_req = 1'b0;
        wdf_full = 1'b1;
        drv(0, 1'b0, '0, 1'b1, 128'h31);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_wdf_full", m0_wdf_full, 1'b1);
            chk("stall_wdf_en", wdf_wr_en, 1'b0);
            chk("stall_gnt", m0_gnt, 1'b1);
            cyc();
        end
        wdf_full = 1'b0;
        exp_q.push_back(128'h31);
        #1;
        chk("stall_release", wdf_wr_en, 1'b1);
        cyc();
        drv(0, 1'b0, '0, 1'b0, '0);
        #1;
        chk("stall_idle", dbg_state, ST_IDLE);

        // Owner drops req before any beat: back to IDLE, last served unchanged (still m0)
        m1_req = 1'b1;
        cyc();
        #1;
        chk("abort_gnt1", m1_gnt, 1'b1);
        m1_req = 1'b0;
        cyc();
        #1;
        chk("abort_idle", dbg_state, ST_IDLE);
        m0_req = 1'b1; m1_req = 1'b1;
        cyc();
        #1;
        chk("abort_tie_gnt1", m1_gnt, 1'b1);

        // m1 drops req after the address beat: grant held until both data beats
        m0_req = 1'b0;
        drv(1, 1'b1, 31'h500, 1'b0, '0);
        cyc();
        m1_req = 1'b0;
        drv(1, 1'b0, '0, 1'b0, '0);
        #1;
        chk("hold_gnt_a", m1_gnt, 1'b1);
        cyc();
        #1;
        chk("hold_gnt_b", m1_gnt, 1'b1);
        drv(1, 1'b0, '0, 1'b1, 128'h50);
        exp_q.push_back(128'h50);
        cyc();
        drv(1, 1'b0, '0, 1'b1, 128'h51);
        exp_q.push_back(128'h51);
        #1;
        chk("hold_gnt_c", m1_gnt, 1'b1);
        cyc();
        drv(1, 1'b0, '0, 1'b0, '0);
        #1;
        chk("hold_idle", dbg_state, ST_IDLE);

        // Reset mid-burst abandons it; fresh m1 burst starts from clean counters
        m0_req = 1'b1;
        cyc();
        drv(0, 1'b1, 31'h600, 1'b1, 128'h60);
        exp_q.push_back(128'h60);
        cyc();
        rst = 1'b1;
        drv(0, 1'b0, '0, 1'b1, 128'h61);
        #1;
        chk("rst_mid_wdf_en", wdf_wr_en, 1'b0);
        cyc();
        rst = 1'b0;
        m0_req = 1'b0;
        drv(0, 1'b0, '0, 1'b0, '0);
        #1;
        chk("rst_mid_gnt0", m0_gnt, 1'b0);
        chk("rst_mid_state", dbg_state, ST_IDLE);
        m1_req = 1'b1;
        cyc();
        #1;
        chk("fresh_gnt1", m1_gnt, 1'b1);
        chk("fresh_af_full", m1_af_full, 1'b0);
        chk("fresh_wdf_full", m1_wdf_full, 1'b0);
        burst(1, 31'h700, 128'h70, 128'h71, 1'b1);

        repeat (2) cyc();
        chk("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
